// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
//  Module   : uart_tx_fifo_pkg
//  Desc     : Shared UART definitions: data width, FSM state encoding, line helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_tx_fifo_pkg;

    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // Serial line level implied by the current frame phase.
    function automatic logic tx_line(input tx_state_e st, input logic data_bit);
        case (st)
            S_START: return 1'b0;
            S_DATA:  return data_bit;
            default: return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Desc     : Bus-side interface of the UART transmitter (write port + status).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_fifo_if #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) ();
    import uart_tx_fifo_pkg::*;

    logic [DIV_W-1:0]    divider;
    logic [c_data_w-1:0] wdata;
    logic                wr;
    logic                full;
    logic                empty;
    logic [FIFO_AW:0]    level;
    logic                ovf;
    logic                busy;
    logic                txd;

    modport master (
        output divider, wdata, wr,
        input  full, empty, level, ovf, busy, txd
    );

    modport slave (
        input  divider, wdata, wr,
        output full, empty, level, ovf, busy, txd
    );

endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo_sync_fifo
//  Desc     : Single-clock show-ahead FIFO with registered full/empty/level.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  wire          clk,
    input  wire          reset,
    input  wire          wr_en,
    input  wire [DW-1:0] wr_data,
    input  wire          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int c_depth = 1 << AW;

    logic [DW-1:0] mem [c_depth];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_wr;
    logic          do_rd;

    // Flags come from the registered state so a pop in the same cycle never
    // opens room for a write that was presented while full.
    always_comb begin
        do_wr  = wr_en && !full_q;
        do_rd  = rd_en && !empty_q;
        wptr_d = do_wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d = do_rd ? rptr_q + 1'b1 : rptr_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == (AW+1)'(c_depth));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Desc     : UART 8N1 transmitter (LSB first) fed by a write-side FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  wire           clk,
    input  wire           reset,
    uart_tx_fifo_if.slave bus
);

    tx_state_e           state_q, state_d;
    logic [c_data_w-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic                pop;
    logic [c_data_w-1:0] fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_AW:0]    fifo_level;

    uart_tx_fifo_sync_fifo #(
        .DW (c_data_w),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wr),
        .wr_data (bus.wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Each phase lasts div_q+1 cycles: baud counts down and the phase
    // advances when it reaches zero. The divider is captured only on a pop.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    div_d   = bus.divider;
                    baud_d  = bus.divider;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = div_q;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = div_q;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d  = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        div_d   = bus.divider;
                        baud_d  = bus.divider;
                        bit_d   = 3'd0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d  = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs trail the state by one cycle, so txd and busy stay
    // aligned with each other over the whole frame.
    always_comb begin
        txd_d  = tx_line(state_q, shift_q[0]);
        busy_d = (state_q != S_IDLE) || !fifo_empty;
        ovf_d  = bus.wr && fifo_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            div_q   <= '0;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;
    assign bus.level = fifo_level;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy_q;
    assign bus.txd   = txd_q;

endmodule

`default_nettype wire
